// File: rtl/round_timer_if.sv
// Control and status bundle between the game logic and the round countdown timer.
// The start/pause/abort/ms_tick inputs and the time_up/load_err outputs are single-cycle
// pulses sampled on posedge clk. No handshake is held or acknowledged, and every output is registered.
interface round_timer_if;
   logic       start;
   logic       pause;
   logic       abort;
   logic [7:0] load_val;
   logic       ms_tick;
   logic       timer_en;
   logic [7:0] secs_bcd;
   logic       running;
   logic       warn;
   logic       time_up;
   logic       load_err;
   logic [1:0] state;

   modport master (
      output start, pause, abort, load_val, ms_tick,
      input  timer_en, secs_bcd, running, warn, time_up, load_err, state
   );

   modport slave (
      input  start, pause, abort, load_val, ms_tick,
      output timer_en, secs_bcd, running, warn, time_up, load_err, state
   );
endinterface

// File: rtl/round_timer_ctrl.sv
// Round countdown controller: accumulates 1 ms ticks into seconds and counts a two-digit BCD
// round time down to zero, with start, pause/resume and abort.
module round_timer_ctrl #(
   parameter int         MS_PER_SEC = 1000,
   parameter logic [7:0] WARN_BCD   = 8'h05
) (
   input  logic         clk,
   input  logic         reset,
   round_timer_if.slave tmr
);

   localparam int CW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
   localparam logic [CW-1:0] MS_LAST = CW'(MS_PER_SEC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    secs_q, secs_d;
   logic [CW-1:0] ms_cnt_q, ms_cnt_d;
   logic          timer_en_q, running_q, running_d;
   logic          warn_q, warn_d;
   logic          time_up_q, time_up_d;
   logic          load_err_q, load_err_d;

   logic          load_ok;
   logic [7:0]    secs_dec;

   assign load_ok = (tmr.load_val[7:4] <= 4'd9) && (tmr.load_val[3:0] <= 4'd9) &&
                    (tmr.load_val != 8'h00);

   // BCD decrement: a zero ones digit borrows from the tens digit.
   assign secs_dec = (secs_q[3:0] == 4'd0) ? {secs_q[7:4] - 4'd1, 4'd9}
                                           : {secs_q[7:4], secs_q[3:0] - 4'd1};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         secs_q     <= 8'h00;
         ms_cnt_q   <= '0;
         timer_en_q <= 1'b0;
         running_q  <= 1'b0;
         warn_q     <= 1'b0;
         time_up_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         secs_q     <= secs_d;
         ms_cnt_q   <= ms_cnt_d;
         timer_en_q <= (state_q == RUN);
         running_q  <= running_d;
         warn_q     <= warn_d;
         time_up_q  <= time_up_d;
         load_err_q <= load_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      secs_d     = secs_q;
      ms_cnt_d   = ms_cnt_q;
      time_up_d  = 1'b0;
      load_err_d = 1'b0;

      if (tmr.abort) begin
         state_d  = IDLE;
         secs_d   = 8'h00;
         ms_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE, EXPIRED: begin
               if (!tmr.pause && tmr.start) begin
                  if (load_ok) begin
                     secs_d   = tmr.load_val;
                     ms_cnt_d = '0;
                     state_d  = RUN;
                  end else begin
                     load_err_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (tmr.ms_tick) begin
                  if (ms_cnt_q == MS_LAST) begin
                     ms_cnt_d = '0;
                     if (secs_q == 8'h01) begin
                        secs_d    = 8'h00;
                        time_up_d = 1'b1;
                        state_d   = EXPIRED;
                     end else begin
                        secs_d = secs_dec;
                     end
                  end else begin
                     ms_cnt_d = ms_cnt_q + 1'b1;
                  end
               end
               // A final tick in the same cycle as pause still expires the round.
               if (tmr.pause && state_d == RUN) begin
                  state_d = PAUSE;
               end
            end
            PAUSE: begin
               if (!tmr.pause && tmr.start) begin
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      running_d = (state_d == RUN);
      warn_d    = ((state_d == RUN) || (state_d == PAUSE)) &&
                  (secs_d <= WARN_BCD) && (secs_d != 8'h00);
   end

   assign tmr.timer_en = timer_en_q;
   assign tmr.secs_bcd = secs_q;
   assign tmr.running  = running_q;
   assign tmr.warn     = warn_q;
   assign tmr.time_up  = time_up_q;
   assign tmr.load_err = load_err_q;
   assign tmr.state    = state_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl: the driver pushes hand-computed output snapshots,
// and the monitor compares them on the negedge following the targeted posedge.
module tb_round_timer_ctrl;

   logic clk;
   logic reset;
   int   cyc;

   round_timer_if tmr ();

   round_timer_ctrl #(.MS_PER_SEC(4), .WARN_BCD(8'h05)) dut (
      .clk   (clk),
      .reset (reset),
      .tmr   (tmr)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: {state, secs, timer_en, running, warn, time_up, load_err}
   logic [14:0] exp_q[$];
   int          exp_cyc_q[$];
   string       exp_name_q[$];
   int          tests_run;
   int          tests_failed;
   bit          done;
   bit          reported;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reported     = 1'b0;
   end

   // driver tasks
   task automatic drive(input logic s, input logic p, input logic a, input logic t,
                        input logic [7:0] lv, input logic rn);
      @(negedge clk);
      tmr.start    = s;
      tmr.pause    = p;
      tmr.abort    = a;
      tmr.ms_tick  = t;
      tmr.load_val = lv;
      reset        = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
   endtask

   task automatic expect_out(input string name, input logic [1:0] st, input logic [7:0] secs,
                             input logic ten, input logic run, input logic wrn,
                             input logic tu, input logic le);
      exp_q.push_back({st, secs, ten, run, wrn, tu, le});
      exp_cyc_q.push_back(cyc);
      exp_name_q.push_back(name);
   endtask

   // monitor
   always @(negedge clk) begin
      logic [14:0] act;
      logic [14:0] exp_v;
      string       nm;
      act = {tmr.state, tmr.secs_bcd, tmr.timer_en, tmr.running, tmr.warn,
             tmr.time_up, tmr.load_err};
      while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
         exp_v = exp_q.pop_front();
         nm    = exp_name_q.pop_front();
         tests_run++;
         if (exp_cyc_q.pop_front() != cyc) begin
            tests_failed++;
            $display("FAIL %s: expectation not sampled in its cycle", nm);
         end else if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got st=%0d secs=%h ten=%b run=%b warn=%b tu=%b le=%b, want st=%0d secs=%h ten=%b run=%b warn=%b tu=%b le=%b",
                     nm, act[14:13], act[12:5], act[4], act[3], act[2], act[1], act[0],
                     exp_v[14:13], exp_v[12:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
      if (done && !reported) begin
         tests_run++;
         if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
         end
         reported = 1'b1;
      end
   end

   // stimulus
   initial begin
      done         = 1'b0;
      reset        = 1'b0;
      tmr.start    = 1'b0;
      tmr.pause    = 1'b0;
      tmr.abort    = 1'b0;
      tmr.ms_tick  = 1'b0;
      tmr.load_val = 8'h00;

      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      expect_out("reset", 2'd0, 8'h00, 0, 0, 0, 0, 0);

      // countdown with BCD borrow and warn threshold
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1);
      expect_out("start_12", 2'd1, 8'h12, 0, 1, 0, 0, 0);
      ticks(4);
      expect_out("secs_11", 2'd1, 8'h11, 1, 1, 0, 0, 0);
      ticks(8);
      expect_out("borrow_09", 2'd1, 8'h09, 1, 1, 0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1);
      expect_out("start_in_run", 2'd1, 8'h09, 1, 1, 0, 0, 0);
      ticks(16);
      expect_out("warn_05", 2'd1, 8'h05, 1, 1, 1, 0, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      expect_out("abort_run", 2'd0, 8'h00, 1, 0, 0, 0, 0);
      idle();
      expect_out("abort_ten_off", 2'd0, 8'h00, 0, 0, 0, 0, 0);

      // expiry
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1);
      expect_out("start_02", 2'd1, 8'h02, 0, 1, 1, 0, 0);
      ticks(4);
      expect_out("secs_01", 2'd1, 8'h01, 1, 1, 1, 0, 0);
      ticks(4);
      expect_out("time_up", 2'd3, 8'h00, 1, 0, 0, 1, 0);
      ticks(1);
      expect_out("expired_ten_off", 2'd3, 8'h00, 0, 0, 0, 0, 0);
      ticks(3);
      expect_out("expired_ticks", 2'd3, 8'h00, 0, 0, 0, 0, 0);

      // rejected loads
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      expect_out("abort_expired", 2'd0, 8'h00, 0, 0, 0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h1A, 1'b1);
      expect_out("load_err_1A", 2'd0, 8'h00, 0, 0, 0, 0, 1);
      idle();
      expect_out("load_err_clear", 2'd0, 8'h00, 0, 0, 0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      expect_out("load_err_00", 2'd0, 8'h00, 0, 0, 0, 0, 1);

      // pause retains ms count
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 1'b1);
      expect_out("start_03", 2'd1, 8'h03, 0, 1, 1, 0, 0);
      ticks(2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      expect_out("pause", 2'd2, 8'h03, 1, 0, 1, 0, 0);
      ticks(10);
      expect_out("pause_ignores_ticks", 2'd2, 8'h03, 0, 0, 1, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h99, 1'b1);
      expect_out("resume", 2'd1, 8'h03, 0, 1, 1, 0, 0);
      ticks(2);
      expect_out("resume_ms_kept", 2'd1, 8'h02, 1, 1, 1, 0, 0);

      // abort beats the final tick
      ticks(7);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
      expect_out("abort_final_tick", 2'd0, 8'h00, 1, 0, 0, 0, 0);
      idle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
      expect_out("start_01", 2'd1, 8'h01, 0, 1, 1, 0, 0);
      ticks(3);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
      expect_out("pause_final_tick", 2'd3, 8'h00, 1, 0, 0, 1, 0);
      idle();
      expect_out("pause_final_after", 2'd3, 8'h00, 0, 0, 0, 0, 0);

      // reset mid-run
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 1'b1);
      expect_out("start_07", 2'd1, 8'h07, 0, 1, 0, 0, 0);
      ticks(2);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      expect_out("reset_mid_run", 2'd0, 8'h00, 0, 0, 0, 0, 0);
      ticks(5);
      expect_out("post_reset_ticks", 2'd0, 8'h00, 0, 0, 0, 0, 0);

      idle();
      idle();
      done = 1'b1;
      for (int i = 0; i < 10 && !reported; i++) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/round_timer_ctrl.md
Name: round_timer_ctrl

Overview:
- Round countdown controller for the BCD math game.
- Drives the enable of the 1 ms LFSR timebase and accumulates its 1 ms timeout pulses into seconds.
- Counts a two-digit BCD round time down to zero, with start, pause/resume and abort.
- Presents BCD seconds to the display logic and signals round expiry to the game FSM.

Parameters:
MS_PER_SEC, 1000, number of ms_tick pulses per second (set small, e.g. 4, in simulation)
WARN_BCD, 8'h05, BCD threshold at or below which warn asserts

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  load/start from IDLE or EXPIRED; resume from PAUSE
pause  input  1  pause request while running
abort  input  1  return to IDLE and clear count
load_val  input  8  round time in BCD, {tens, ones}
ms_tick  input  1  1-cycle timeout pulse from the 1 ms timebase
timer_en  output  1  enable to the 1 ms timebase
secs_bcd  output  8  remaining seconds, BCD
running  output  1  high in RUN
warn  output  1  low-time indicator
time_up  output  1  1-cycle pulse when the count reaches 00
load_err  output  1  1-cycle pulse when a start is rejected
state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, EXPIRED=3

Behaviour:
Reset (reset==0 at posedge clk):
- state=IDLE; secs_bcd=8'h00; ms_cnt=0.
- timer_en=0, running=0, warn=0, time_up=0, load_err=0.
- All outputs are registered.

Input priority per cycle: abort > pause > start. At most one control action is taken per cycle.

IDLE / EXPIRED, on start:
- If load_val has both nibbles <=9 and is nonzero: secs_bcd<=load_val, ms_cnt<=0, go to RUN.
- Otherwise: stay in the current state, secs_bcd unchanged, load_err=1 for one cycle.

RUN:
- timer_en=1, registered: it goes high the cycle after entering RUN and low the cycle after leaving it.
- On ms_tick, if ms_cnt != MS_PER_SEC-1: ms_cnt++.
- On ms_tick, if ms_cnt == MS_PER_SEC-1: ms_cnt<=0 and secs_bcd is BCD-decremented.
  - Ones==0 gives ones=9 and tens-1; otherwise ones-1.
  - If secs_bcd was 8'h01: secs_bcd<=8'h00, time_up=1 for one cycle, go to EXPIRED.

RUN, on pause:
- Go to PAUSE; ms_cnt is retained.
- An ms_tick in the same cycle is still counted, including the final tick, which then goes to EXPIRED instead of PAUSE.

PAUSE:
- timer_en=0 and ms_tick is ignored.
- start resumes RUN with ms_cnt and secs_bcd preserved; load_val is ignored.
- pause has no effect.

EXPIRED:
- secs_bcd=00, timer_en=0.
- start reloads as from IDLE.

abort, in any state:
- Go to IDLE, secs_bcd<=00, ms_cnt<=0, no time_up.
- abort beats a simultaneous final ms_tick.

Other rules:
- ms_tick is ignored outside RUN.
- start in RUN has no effect.
- warn = (state is RUN or PAUSE) and secs_bcd <= WARN_BCD and secs_bcd != 00. It is computed from the next-state values so that it aligns with secs_bcd.
- running = (state == RUN).
- ms_cnt is wide enough for MS_PER_SEC-1 and is never exposed.

Test Plan:
- MS_PER_SEC=4, load_val=8'h12, start, then 4 ms_tick pulses -> secs_bcd=8'h11; after 8 more -> 8'h09 (BCD borrow), warn=0; after 16 more -> 8'h05, warn=1.
- load_val=8'h02, start, 8 ms_ticks -> secs 01 then 00; time_up high exactly one cycle; state=EXPIRED; timer_en=0 next cycle; further ticks leave secs_bcd=00.
- load_val=8'h1A, then 8'h00, each with start -> load_err pulse each time, state stays IDLE, secs_bcd=00.
- RUN at secs=8'h03 with ms_cnt=2, pause -> PAUSE, 10 ms_ticks ignored; start -> RUN, 2 ticks -> secs=8'h02.
- secs=8'h01, ms_cnt=3, ms_tick and abort in the same cycle -> IDLE, secs=00, no time_up. Repeat with pause instead of abort -> EXPIRED with time_up.
- reset low mid-RUN at secs=8'h07 -> all outputs at reset values next cycle; ms_ticks ignored until a new start.
